mem_stage: RTL

- Memory-access stage directly downstream of the ALU/alu_mem pipeline register.
- Consumes the ALU result, write-back info, pc and instruction.
- Performs load/store transactions on a req/gnt/rvalid data bus, stalling the pipeline while a transaction is outstanding.
- Registers its results into the write-back stage.
- Non-memory instructions pass through with 1-cycle latency.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/load_align.sv | 38 +++
 rtl/mem_stage.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_pkg
// Brief   : Opcode/funct3 constants, FSM encoding and decode helpers for mem_stage.
// Rev     : 1.0
// ============================================================================
package mem_pkg;

    localparam logic [6:0] c_opc_load  = 7'b0000011;
    localparam logic [6:0] c_opc_store = 7'b0100011;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    localparam int c_be_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mem_state_e;

    function automatic logic is_load_f3(input logic [2:0] f3);
        return (f3 == c_f3_lb) || (f3 == c_f3_lh) || (f3 == c_f3_lw) ||
               (f3 == c_f3_lbu) || (f3 == c_f3_lhu);
    endfunction

    function automatic logic is_store_f3(input logic [2:0] f3);
        return (f3 == c_f3_sb) || (f3 == c_f3_sh) || (f3 == c_f3_sw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Selects the byte/half lane of load data and sign/zero-extends it.
// Rev    : 1.0
// ============================================================================
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            c_f3_lb:  o_result = {{24{w_byte[7]}}, w_byte};
            c_f3_lbu: o_result = {24'b0, w_byte};
            c_f3_lh:  o_result = {{16{w_half[15]}}, w_half};
            c_f3_lhu: o_result = {16'b0, w_half};
            default:  o_result = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_stage
// Brief  : Load/store stage on a req/gnt/rvalid bus; optional MEM_MISALIGN_TRAP_EN.
// Rev    : 1.0
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_valid_i,
    input  logic [31:0]         mem_inst_i,
    input  logic [31:0]         mem_pc_i,
    input  logic [DATA_W-1:0]   mem_reg_wdata_i,
    input  logic [DATA_W-1:0]   mem_store_data_i,
    input  logic                mem_wr_reg_en_i,
    input  logic [4:0]          mem_wr_reg_addr_i,
    output logic                mem_stall_o,
    output logic                dbus_req_o,
    output logic                dbus_we_o,
    output logic [ADDR_W-1:0]   dbus_addr_o,
    output logic [DATA_W-1:0]   dbus_wdata_o,
    output logic [c_be_w-1:0]   dbus_be_o,
    input  logic                dbus_gnt_i,
    input  logic                dbus_rvalid_i,
    input  logic [DATA_W-1:0]   dbus_rdata_i,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                misalign_o,
    output logic [ADDR_W-1:0]   misalign_addr_o,
`endif
    output logic                wb_valid_o,
    output logic                wb_wr_reg_en_o,
    output logic [4:0]          wb_wr_reg_addr_o,
    output logic [DATA_W-1:0]   wb_reg_wdata_o,
    output logic [31:0]         wb_pc_o,
    output logic [31:0]         wb_inst_o
);

    mem_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [c_be_w-1:0]   be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                rd_en_q, rd_en_d;
    logic [4:0]          rd_q, rd_d;
    logic [31:0]         pc_q, pc_d, inst_q, inst_d;

    logic                wb_valid_q, wb_valid_d;
    logic                wb_en_q, wb_en_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [31:0]         wb_pc_q, wb_pc_d, wb_inst_q, wb_inst_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic                misalign_q, misalign_d;
    logic [ADDR_W-1:0]   misalign_addr_q, misalign_addr_d;
`endif

    logic [2:0]          w_f3;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_is_load, w_is_store, w_misalign, w_mem_op;
    logic [c_be_w-1:0]   w_be_in;
    logic [DATA_W-1:0]   w_wdata_in;
    logic [31:0]         w_load_data;

    assign w_f3       = mem_inst_i[14:12];
    assign w_addr     = mem_reg_wdata_i[ADDR_W-1:0];
    assign w_is_load  = (mem_inst_i[6:0] == c_opc_load)  && is_load_f3(w_f3);
    assign w_is_store = (mem_inst_i[6:0] == c_opc_store) && is_store_f3(w_f3);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = (w_is_load || w_is_store) &&
                        (((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                         ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00)));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_mem_op = mem_valid_i && (w_is_load || w_is_store) && !w_misalign;

    always_comb begin
        case (w_f3[1:0])
            2'b00: begin
                w_be_in    = 4'b0001 << w_addr[1:0];
                w_wdata_in = {4{mem_store_data_i[7:0]}};
            end
            2'b01: begin
                w_be_in    = 4'b0011 << {w_addr[1], 1'b0};
                w_wdata_in = {2{mem_store_data_i[15:0]}};
            end
            default: begin
                w_be_in    = 4'b1111;
                w_wdata_in = mem_store_data_i;
            end
        endcase
    end

    load_align u_load_align (
        .i_rdata   (dbus_rdata_i),
        .i_addr_lo (addr_q[1:0]),
        .i_funct3  (funct3_q),
        .o_result  (w_load_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        rd_en_d   = rd_en_q;
        rd_d      = rd_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_pc_d    = wb_pc_q;
        wb_inst_d  = wb_inst_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
`endif
        mem_stall_o  = 1'b0;
        dbus_req_o   = 1'b0;
        dbus_we_o    = we_q;
        dbus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        dbus_be_o    = be_q;
        dbus_wdata_o = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (w_mem_op) begin
                    // First request cycle is driven straight from the inputs.
                    dbus_req_o   = 1'b1;
                    dbus_we_o    = w_is_store;
                    dbus_addr_o  = {w_addr[ADDR_W-1:2], 2'b00};
                    dbus_be_o    = w_be_in;
                    dbus_wdata_o = w_wdata_in;
                    addr_d   = w_addr;
                    we_d     = w_is_store;
                    be_d     = w_be_in;
                    wdata_d  = w_wdata_in;
                    funct3_d = w_f3;
                    rd_en_d  = mem_wr_reg_en_i;
                    rd_d     = mem_wr_reg_addr_i;
                    pc_d     = mem_pc_i;
                    inst_d   = mem_inst_i;
                    if (dbus_gnt_i && w_is_store) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = mem_wr_reg_addr_i;
                        wb_data_d  = mem_reg_wdata_i;
                        wb_pc_d    = mem_pc_i;
                        wb_inst_d  = mem_inst_i;
                    end else begin
                        mem_stall_o = 1'b1;
                        state_d     = dbus_gnt_i ? ST_WAIT_R : ST_REQ;
                    end
                end else if (mem_valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_en_d    = mem_wr_reg_en_i && !w_misalign;
                    wb_rd_d    = mem_wr_reg_addr_i;
                    wb_data_d  = mem_reg_wdata_i;
                    wb_pc_d    = mem_pc_i;
                    wb_inst_d  = mem_inst_i;
`ifdef MEM_MISALIGN_TRAP_EN
                    misalign_d = w_misalign;
                    if (w_misalign) begin
                        misalign_addr_d = w_addr;
                    end
`endif
                end
            end
            ST_REQ: begin
                dbus_req_o  = 1'b1;
                mem_stall_o = !(dbus_gnt_i && we_q);
                if (dbus_gnt_i) begin
                    if (we_q) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = DATA_W'(addr_q);
                        wb_pc_d    = pc_q;
                        wb_inst_d  = inst_q;
                    end else begin
                        state_d = ST_WAIT_R;
                    end
                end
            end
            ST_WAIT_R: begin
                mem_stall_o = !dbus_rvalid_i;
                if (dbus_rvalid_i) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_en_d    = rd_en_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = w_load_data;
                    wb_pc_d    = pc_q;
                    wb_inst_d  = inst_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            funct3_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_q       <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_pc_q    <= '0;
            wb_inst_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            rd_en_q    <= rd_en_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_pc_q    <= wb_pc_d;
            wb_inst_q  <= wb_inst_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
`endif
        end
    end

    assign wb_valid_o       = wb_valid_q;
    assign wb_wr_reg_en_o   = wb_en_q;
    assign wb_wr_reg_addr_o = wb_rd_q;
    assign wb_reg_wdata_o   = wb_data_q;
    assign wb_pc_o          = wb_pc_q;
    assign wb_inst_o        = wb_inst_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_o       = misalign_q;
    assign misalign_addr_o  = misalign_addr_q;
`endif

endmodule
`default_nettype wire
